// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode/funct constants, FSM states and ALU controls for multicycle_cpu
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: is_supported = 1'b1;
                    default:                               is_supported = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW: is_supported = 1'b1;
            default: is_supported = 1'b0;
        endcase
    endfunction

    // Branches compare through a subtract so the zero flag decides taken/not taken.
    function automatic alu_op_t alu_ctrl(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            OP_SLTI:        alu_ctrl = ALU_SLT;
            OP_BEQ, OP_BNE: alu_ctrl = ALU_SUB;
            default:        alu_ctrl = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_cpu_if.sv
// rtl/multicycle_cpu_if.sv - single-outstanding memory request/ready bus
interface multicycle_cpu_if #(
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational add/sub/and/or/slt ALU with zero flag
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_t           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle MIPS-subset core; MULTICYCLE_CPU_TRAP_EN halts on unsupported instructions
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                REG_NUM  = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_cpu_if.master  mem,
    output logic              retire_o,
    output logic              halt_o
);

    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_pc, r_a, r_b, r_imm, r_res;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_regs [REG_NUM];

    logic [5:0]        w_op, w_fn;
    logic [4:0]        w_rs, w_rt, w_rd, w_wb_idx;
    logic [DATA_W-1:0] w_alu_b, w_alu_res, w_br_target, w_j_target;
    logic [DATA_W-1:0] w_addr, w_wdata;
    alu_op_t           w_alu_op;
    logic              w_zero, w_supported, w_taken, w_is_sw;
    logic              w_req, w_we, w_retire, w_unused;

    assign w_op        = r_ir[31:26];
    assign w_rs        = r_ir[25:21];
    assign w_rt        = r_ir[20:16];
    assign w_rd        = r_ir[15:11];
    assign w_fn        = r_ir[5:0];
    assign w_unused    = ^r_ir[10:6];
    assign w_wb_idx    = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_is_sw     = (w_op == OP_SW);
    assign w_supported = is_supported(w_op, w_fn);
    assign w_alu_op    = alu_ctrl(w_op, w_fn);
    assign w_alu_b     = (w_op == OP_RTYPE || w_op == OP_BEQ || w_op == OP_BNE) ? r_b : r_imm;
    assign w_taken     = (w_op == OP_BEQ && w_zero) || (w_op == OP_BNE && !w_zero);
    // r_pc already holds PC+4 once the fetch has completed.
    assign w_br_target = r_pc + (r_imm << 2);
    assign w_j_target  = {r_pc[DATA_W-1:28], r_ir[25:0], 2'b00};

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_alu_op),
        .i_a      (r_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_res),
        .o_zero   (w_zero)
    );

    function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= REG_NUM) return '0;
        return r_regs[idx[IDX_W-1:0]];
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req  = 1'b1;
                w_addr = r_pc;
                if (mem.mem_ready_i) w_next = S_DECODE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (!w_supported) begin
`ifdef MULTICYCLE_CPU_TRAP_EN
                    w_next = S_HALT;
`else
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
`endif
                end else begin
                    case (w_op)
                        OP_RTYPE, OP_ADDI, OP_SLTI: w_next = S_WB;
                        OP_LW, OP_SW:               w_next = S_MEM;
                        default: begin
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end
                    endcase
                end
            end
            S_MEM: begin
                w_req   = 1'b1;
                w_we    = w_is_sw;
                w_addr  = r_res;
                w_wdata = w_is_sw ? r_b : '0;
                if (mem.mem_ready_i) begin
                    w_retire = w_is_sw;
                    w_next   = w_is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Gating with rst_i makes an in-flight request vanish the instant reset asserts.
    assign mem.mem_req_o   = w_req & rst_i;
    assign mem.mem_we_o    = w_we & rst_i;
    assign mem.mem_addr_o  = rst_i ? w_addr : '0;
    assign mem.mem_wdata_o = rst_i ? w_wdata : '0;
    assign retire_o        = w_retire & rst_i;
`ifdef MULTICYCLE_CPU_TRAP_EN
    assign halt_o = (r_state == S_HALT);
`else
    assign halt_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_res <= '0;
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem.mem_ready_i) begin
                        r_ir <= mem.mem_rdata_i[31:0];
                        r_pc <= r_pc + DATA_W'(4);
                    end
                end
                S_DECODE: begin
                    r_a   <= read_reg(w_rs);
                    r_b   <= read_reg(w_rt);
                    r_imm <= {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
                end
                S_EXEC: begin
                    r_res <= w_alu_res;
                    if (w_supported && w_taken)  r_pc <= w_br_target;
                    if (w_supported && w_op == OP_J) r_pc <= w_j_target;
                end
                S_MEM: begin
                    if (mem.mem_ready_i && !w_is_sw) r_res <= mem.mem_rdata_i;
                end
                S_WB: begin
                    if (w_wb_idx != 5'd0 && int'(w_wb_idx) < REG_NUM)
                        r_regs[w_wb_idx[IDX_W-1:0]] <= r_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter DATA_W, default 32, datapath/register/address width; legal values ≥32.
REQ-002 Parameter REG_NUM, default 32, number of implemented registers (2..32).
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 mem_req_o  output  1  memory request valid.
REQ-007 mem_we_o  output  1  1 = store, 0 = load/fetch; meaningful only while mem_req_o=1.
REQ-008 mem_addr_o  output  DATA_W  byte address of the request.
REQ-009 mem_wdata_o  output  DATA_W  store data.
REQ-010 mem_ready_i  input  1  memory completes the request in the cycle it is sampled high with mem_req_o.
REQ-011 mem_rdata_i  input  DATA_W  read data, valid in the completing cycle; instruction = bits [31:0].
REQ-012 retire_o  output  1  one-cycle pulse when an instruction completes.
REQ-013 halt_o  output  1  core halted (see Configuration).

Function
REQ-014 The core SHALL be a multi-cycle FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 FETCH SHALL assert mem_req_o, mem_we_o=0, mem_addr_o=PC, hold them stable until mem_ready_i=1, then latch IR, set PC=PC+4, go to DECODE.
REQ-016 DECODE SHALL read rs/rt, sign-extend imm[15:0] to DATA_W, go to EXEC.
REQ-017 Supported: R-type (op 0x00) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08, slti 0x0A, beq 0x04, bne 0x05, lw 0x23, sw 0x2B, j 0x02.
REQ-018 Arithmetic SHALL wrap modulo 2^DATA_W; slt/slti SHALL compare signed, result 1 or 0 zero-extended.
REQ-019 EXEC for R-type/addi/slti SHALL go to WB; lw/sw to MEM with address rs+sext(imm); beq/bne/j to FETCH with retire_o=1.
REQ-020 Taken branch target SHALL be PC+4+(sext(imm)<<2); j target SHALL be {PC+4[DATA_W-1:28], imm26, 2'b00}.
REQ-021 MEM SHALL hold the request stable until mem_ready_i=1; sw then goes to FETCH with retire_o=1; lw latches read data and goes to WB.
REQ-022 WB SHALL write rd (R-type) or rt (I-type, lw), pulse retire_o, go to FETCH.
REQ-023 Zero-wait latencies SHALL be: branch/jump 3 cycles, ALU 4, sw 4, lw 5; each mem_ready_i=0 cycle adds one.
REQ-024 Register 0 SHALL read 0 and ignore writes; indices ≥ REG_NUM SHALL read 0 and ignore writes.
REQ-025 mem_req_o SHALL be 0 in DECODE, EXEC, WB, HALT; at most one request outstanding.
REQ-026 mem_addr_o SHALL be issued unmodified; alignment is the memory's responsibility.

Reset
REQ-027 While rst_i=0: state FETCH, PC=RESET_PC, all registers 0, IR 0, mem_req_o=0, retire_o=0, halt_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-028 Reset assertion mid-request SHALL drop mem_req_o immediately (asynchronously); the aborted access has no architectural effect.
REQ-029 The first cycle after rst_i rises SHALL assert mem_req_o with mem_addr_o=RESET_PC.

Configuration
REQ-030 Macro MULTICYCLE_CPU_TRAP_EN defined: an unsupported opcode/funct in EXEC SHALL enter HALT, assert halt_o until reset, no retire_o, no state change.
REQ-031 Macro undefined: an unsupported instruction SHALL execute as a NOP (retire_o pulse, PC+4) and halt_o SHALL be tied 0.

Structure
REQ-032 Package cpu_pkg SHALL hold opcode/funct constants, FSM state enum, ALU control codes.
REQ-033 Sub-module cpu_alu (combinational, DATA_W-parametrised: add/sub/and/or/slt, zero flag) SHALL be instantiated once; register file stays inside multicycle_cpu.

Verification
REQ-034 Reset release, RESET_PC=0x100, zero-wait memory -> first fetch addr 0x100 in first cycle, mem_we_o=0.
REQ-035 addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1, four retire pulses, 4 cycles apart.
REQ-036 sw $3,8($0); lw $5,8($0) with 2 ready-low cycles each -> store addr 8 data 2, $5=2, lw takes 7 cycles, request held stable.
REQ-037 beq $1,$1,-1 at 0x20 -> next fetch 0x20; bne $1,$1,+4 -> next fetch PC+4; addi $0,$0,7 -> $0 stays 0.
REQ-038 Opcode 0x3F -> with TRAP_EN halt_o=1, no further requests; without, retire_o pulse, next fetch PC+4.
REQ-039 DATA_W=64, REG_NUM=16: add wraps at 2^64, write to $20 ignored, read $20 returns 0; rst_i low during MEM wait -> mem_req_o drops same cycle, refetch RESET_PC.
